encoder: RTL and testbench

- Streaming systematic Reed-Solomon encoder over GF(2^EGF_DIM). Accepts ENC_SYM symbols per clock and emits a codeword stream of the same width.
- Each frame is MSG_SYM message symbols, passed through unchanged, followed by PAR_SYM parity symbols that the block computes.
- Sits between the data generator and the line/channel stage. There is no handshake; framing is fixed by an internal cycle counter.

---
 rtl/encoder.sv | 107 ++++++++++
 tb/tb_encoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/encoder.sv
// Streaming systematic Reed-Solomon encoder: MSG_SYM message symbols pass through, then PAR_SYM parity symbols.
// Latency 1 cycle (2 with ENC_OUT_PIPE_EN); no backpressure, framing is set by a free-running position counter.
module encoder #(
  parameter int EGF_DIM = 8,
  parameter int ENC_SYM = 2,
  parameter int MSG_SYM = 8,
  parameter int PAR_SYM = 4,
  parameter int GF_POLY = 'h11D
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ENC_SYM*EGF_DIM-1:0] gen_data,
  output logic [ENC_SYM*EGF_DIM-1:0] enc_data
);

  localparam int W     = ENC_SYM * EGF_DIM;
  localparam int M     = MSG_SYM / ENC_SYM;
  localparam int P     = PAR_SYM / ENC_SYM;
  localparam int FRAME = M + P;
  localparam int POS_W = (FRAME > 1) ? $clog2(FRAME) : 1;

  localparam logic [EGF_DIM-1:0] POLY_LO = EGF_DIM'(GF_POLY);
  localparam logic [POS_W-1:0]   M_POS   = POS_W'(M);
  localparam logic [POS_W-1:0]   LAST    = POS_W'(FRAME - 1);

  typedef logic [PAR_SYM-1:0][EGF_DIM-1:0] par_t;

  function automatic logic [EGF_DIM-1:0] gf_mul(input logic [EGF_DIM-1:0] a,
                                                input logic [EGF_DIM-1:0] b);
    logic [EGF_DIM-1:0] acc;
    logic [EGF_DIM-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < EGF_DIM; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[EGF_DIM-1] ? ((sh << 1) ^ POLY_LO) : (sh << 1);
    end
    return acc;
  endfunction

  // Expands prod (x - alpha^i); the monic leading term is implicit.
  function automatic par_t gen_poly();
    logic [PAR_SYM:0][EGF_DIM-1:0] g;
    logic [EGF_DIM-1:0]            root;
    g    = '0;
    g[0] = EGF_DIM'(1);
    root = EGF_DIM'(1);
    for (int i = 0; i < PAR_SYM; i++) begin
      for (int k = PAR_SYM; k > 0; k--) g[k] = g[k-1] ^ gf_mul(g[k], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, EGF_DIM'(2));
    end
    return g[PAR_SYM-1:0];
  endfunction

  localparam par_t G = gen_poly();

  logic [POS_W-1:0] pos_q;
  par_t             par_q;
  par_t             par_d;
  logic [W-1:0]     out_q;
  logic [W-1:0]     out_d;

  always_comb begin : lfsr_comb
    logic [EGF_DIM-1:0] fb;
    fb    = '0;
    out_d = gen_data;
    // A frame always starts from a clean LFSR, whatever the previous frame left.
    par_d = (pos_q == '0) ? '0 : par_q;
    if (pos_q < M_POS) begin
      for (int i = 0; i < ENC_SYM; i++) begin
        fb = gen_data[(ENC_SYM-1-i)*EGF_DIM +: EGF_DIM] ^ par_d[PAR_SYM-1];
        for (int k = PAR_SYM - 1; k > 0; k--) par_d[k] = par_d[k-1] ^ gf_mul(G[k], fb);
        par_d[0] = gf_mul(G[0], fb);
      end
    end else begin
      for (int i = 0; i < ENC_SYM; i++) out_d[(ENC_SYM-1-i)*EGF_DIM +: EGF_DIM] = par_q[PAR_SYM-1-i];
      par_d = par_q << W;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q <= '0;
      par_q <= '0;
      out_q <= '0;
    end else begin
      pos_q <= (pos_q == LAST) ? '0 : pos_q + 1'b1;
      par_q <= par_d;
      out_q <= out_d;
    end
  end

`ifdef ENC_OUT_PIPE_EN
  logic [W-1:0] pipe_q;

  always_ff @(posedge clk) begin
    if (!rst_n) pipe_q <= '0;
    else        pipe_q <= out_q;
  end

  assign enc_data = pipe_q;
`else
  assign enc_data = out_q;
`endif

endmodule

// File: tb/tb_encoder.sv
// Directed bench for encoder: reset, pass-through, parity vectors, framing and mid-frame reset.
module tb_encoder;

`ifdef ENC_OUT_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int N = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] gen_data;
  logic [15:0] enc_data;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .gen_data (gen_data),
    .enc_data (enc_data)
  );

  // Drives N consecutive cycles (three frames), capturing enc_data after each edge.
  task automatic run_frames(input logic [15:0] din [N], output logic [15:0] dout [N]);
    for (int i = 0; i < N; i++) begin
      gen_data = din[i];
      @(posedge clk);
      #1;
      dout[i] = enc_data;
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    gen_data = 'x;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (enc_data !== 16'h0000) begin
        errors++;
        $display("FAIL reset_%0d got %h want 0000", i, enc_data);
      end
    end
  endtask

  task automatic test_pass_through();
    logic [15:0] din [N];
    logic [15:0] dout [N];
    logic [15:0] exp_w [4];
    exp_w = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    din = '{default: 16'h0000};
    for (int i = 0; i < 4; i++) din[i] = exp_w[i];
    din[4] = 'x;
    din[5] = 'x;
    rst_n = 1'b1;
    run_frames(din, dout);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout[i+LAT-1] !== exp_w[i]) begin
        errors++;
        $display("FAIL pass_%0d got %h want %h", i, dout[i+LAT-1], exp_w[i]);
      end
    end
    for (int i = 10; i < 12; i++) begin
      checks++;
      if (dout[i+LAT-1] !== 16'h0000) begin
        errors++;
        $display("FAIL pass_zero_par_%0d got %h want 0000", i, dout[i+LAT-1]);
      end
    end
  endtask

  task automatic test_unit_message();
    logic [15:0] din [N];
    logic [15:0] dout [N];
    din = '{default: 16'h0000};
    din[3]  = 16'h0001;
    din[4]  = 'x;
    din[5]  = 'x;
    din[10] = 'x;
    din[11] = 'x;
    run_frames(din, dout);
    checks++;
    if (dout[3+LAT-1] !== 16'h0001) begin
      errors++;
      $display("FAIL unit_msg got %h want 0001", dout[3+LAT-1]);
    end
    checks++;
    if (dout[4+LAT-1] !== 16'h0F36) begin
      errors++;
      $display("FAIL unit_par0 got %h want 0f36", dout[4+LAT-1]);
    end
    checks++;
    if (dout[5+LAT-1] !== 16'h7840) begin
      errors++;
      $display("FAIL unit_par1 got %h want 7840", dout[5+LAT-1]);
    end
    // Following all-zero frame with X in its parity slots must give clean zero parity.
    checks++;
    if (dout[10+LAT-1] !== 16'h0000) begin
      errors++;
      $display("FAIL indep_par0 got %h want 0000", dout[10+LAT-1]);
    end
    checks++;
    if (dout[11+LAT-1] !== 16'h0000) begin
      errors++;
      $display("FAIL indep_par1 got %h want 0000", dout[11+LAT-1]);
    end
  endtask

  task automatic test_all_zero();
    logic [15:0] din [N];
    logic [15:0] dout [N];
    din = '{default: 16'h0000};
    run_frames(din, dout);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (dout[i+LAT-1] !== 16'h0000) begin
        errors++;
        $display("FAIL zero_%0d got %h want 0000", i, dout[i+LAT-1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] din [N];
    logic [15:0] dout [N];
    logic [15:0] exp_w [4];
    int          idx [4];
    // m(x)=x gives x^5 mod g = 63 x^3 + 57 x^2 + D2 x + E7; then the unit message.
    exp_w = '{16'h6357, 16'hD2E7, 16'h0F36, 16'h7840};
    idx   = '{4, 5, 10, 11};
    din = '{default: 16'h0000};
    din[3] = 16'h0100;
    din[9] = 16'h0001;
    run_frames(din, dout);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dout[idx[i]+LAT-1] !== exp_w[i]) begin
        errors++;
        $display("FAIL b2b_%0d got %h want %h", i, dout[idx[i]+LAT-1], exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] din [N];
    logic [15:0] dout [N];
    gen_data = 16'h1111;
    @(posedge clk);
    #1;
    gen_data = 16'h2222;
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    gen_data = 16'h3333;
    @(posedge clk);
    #1;
    checks++;
    if (enc_data !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_out got %h want 0000", enc_data);
    end
    rst_n = 1'b1;
    din = '{default: 16'h0000};
    din[3] = 16'h0001;
    run_frames(din, dout);
    checks++;
    if (dout[4+LAT-1] !== 16'h0F36) begin
      errors++;
      $display("FAIL midrst_par0 got %h want 0f36", dout[4+LAT-1]);
    end
    checks++;
    if (dout[5+LAT-1] !== 16'h7840) begin
      errors++;
      $display("FAIL midrst_par1 got %h want 7840", dout[5+LAT-1]);
    end
  endtask

  initial begin
    gen_data = 'x;
    test_reset();
    test_pass_through();
    test_unit_message();
    test_all_zero();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
